bus_arbiter_rr: RTL and testbench

//  Parametrised bus arbiter for the shared system bus; successor to the fixed 4-master arbiter.

---
 rtl/bus_arbiter_rr.sv | 145 ++++++++++++++
 tb/tb_bus_arbiter_rr.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_rr.sv
// Shared-bus arbiter for NUM_MASTERS active-low requesters. Arbitration is
// round-robin or fixed-priority, and a hold limit preempts long-running owners.
module bus_arbiter_rr #(
    parameter int NUM_MASTERS = 4,
    parameter int MAX_HOLD    = 16,
    parameter int RR_MODE     = 1,
    localparam int IDX_W      = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_MASTERS-1:0] req_,
    output logic [NUM_MASTERS-1:0] grnt_,
    output logic [IDX_W-1:0]       owner,
    output logic                   busy,
    output logic                   preempt
);

    localparam int unsigned NM       = NUM_MASTERS;
    localparam logic [7:0]  HOLD_LIM = (MAX_HOLD == 0) ? 8'hFF : 8'(MAX_HOLD - 1);

    typedef enum logic {IDLE, OWNED} state_t;

    state_t                 state_q, state_d;
    logic [NUM_MASTERS-1:0] grnt_q, grnt_d;
    logic [IDX_W-1:0]       owner_q, owner_d;
    logic [7:0]             hold_cnt_q, hold_cnt_d;
    logic                   busy_q, busy_d;
    logic                   preempt_q, preempt_d;

    logic [NUM_MASTERS-1:0] req;
    logic [NUM_MASTERS-1:0] others;
    logic [IDX_W:0]         win_all;
    logic [IDX_W:0]         win_oth;
    logic                   do_grant;
    logic [IDX_W-1:0]       grant_idx;

    // Returns {found, index}. Round-robin scans from last+1 and wraps, so the
    // previous holder is considered last.
    function automatic logic [IDX_W:0] pick(input logic [NUM_MASTERS-1:0] cand,
                                            input logic [IDX_W-1:0]       last);
        logic             found;
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] pos;
        found = 1'b0;
        idx   = '0;
        pos   = '0;
        for (int unsigned k = 0; k < NM; k++) begin
            if (RR_MODE != 0) begin
                pos = IDX_W'((32'(last) + 32'd1 + k) % NM);
            end else begin
                pos = IDX_W'(k);
            end
            if (!found && cand[pos]) begin
                found = 1'b1;
                idx   = pos;
            end
        end
        return {found, idx};
    endfunction

    always_comb begin
        req             = ~req_;
        others          = req;
        others[owner_q] = 1'b0;
        win_all         = pick(req, owner_q);
        win_oth         = pick(others, owner_q);

        state_d    = state_q;
        owner_d    = owner_q;
        grnt_d     = grnt_q;
        hold_cnt_d = hold_cnt_q;
        preempt_d  = 1'b0;
        do_grant   = 1'b0;
        grant_idx  = owner_q;

        unique case (state_q)
            IDLE: begin
                if (win_all[IDX_W]) begin
                    do_grant  = 1'b1;
                    grant_idx = win_all[IDX_W-1:0];
                end
            end
            OWNED: begin
                if (req[owner_q]) begin
                    if (MAX_HOLD == 0 || hold_cnt_q < HOLD_LIM) begin
                        if (hold_cnt_q != 8'hFF) begin
                            hold_cnt_d = hold_cnt_q + 8'd1;
                        end
                    end else if (win_oth[IDX_W]) begin
                        do_grant  = 1'b1;
                        grant_idx = win_oth[IDX_W-1:0];
                        preempt_d = 1'b1;
                    end
                    // At the limit with nobody waiting the count simply saturates.
                end else if (win_all[IDX_W]) begin
                    do_grant  = 1'b1;
                    grant_idx = win_all[IDX_W-1:0];
                end else begin
                    state_d    = IDLE;
                    grnt_d     = '1;
                    hold_cnt_d = '0;
                end
            end
            default: begin
                state_d    = IDLE;
                grnt_d     = '1;
                hold_cnt_d = '0;
            end
        endcase

        if (do_grant) begin
            state_d           = OWNED;
            owner_d           = grant_idx;
            grnt_d            = '1;
            grnt_d[grant_idx] = 1'b0;
            hold_cnt_d        = '0;
        end

        busy_d = (state_d == OWNED);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            grnt_q     <= '1;
            owner_q    <= '0;
            hold_cnt_q <= '0;
            busy_q     <= 1'b0;
            preempt_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grnt_q     <= grnt_d;
            owner_q    <= owner_d;
            hold_cnt_q <= hold_cnt_d;
            busy_q     <= busy_d;
            preempt_q  <= preempt_d;
        end
    end

    assign grnt_   = grnt_q;
    assign owner   = owner_q;
    assign busy    = busy_q;
    assign preempt = preempt_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed checks for bus_arbiter_rr across round-robin, fixed-priority,
// hold-limit and width variants sharing one clock and reset.
module tb_bus_arbiter_rr;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [3:0]  req_rr, grnt_rr;
    logic [1:0]  owner_rr;
    logic        busy_rr, preempt_rr;
    logic [3:0]  req_fp, grnt_fp;
    logic [1:0]  owner_fp;
    logic        busy_fp, preempt_fp;
    logic [3:0]  req_to, grnt_to;
    logic [1:0]  owner_to;
    logic        busy_to, preempt_to;
    logic [1:0]  req_n2, grnt_n2;
    logic        owner_n2;
    logic        busy_n2, preempt_n2;
    logic [15:0] req_n16, grnt_n16;
    logic [3:0]  owner_n16;
    logic        busy_n16, preempt_n16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bus_arbiter_rr #(.NUM_MASTERS(4), .MAX_HOLD(16), .RR_MODE(1)) u_rr (
        .clk(clk), .rst(rst), .req_(req_rr), .grnt_(grnt_rr),
        .owner(owner_rr), .busy(busy_rr), .preempt(preempt_rr));

    bus_arbiter_rr #(.NUM_MASTERS(4), .MAX_HOLD(16), .RR_MODE(0)) u_fp (
        .clk(clk), .rst(rst), .req_(req_fp), .grnt_(grnt_fp),
        .owner(owner_fp), .busy(busy_fp), .preempt(preempt_fp));

    bus_arbiter_rr #(.NUM_MASTERS(4), .MAX_HOLD(4), .RR_MODE(1)) u_to (
        .clk(clk), .rst(rst), .req_(req_to), .grnt_(grnt_to),
        .owner(owner_to), .busy(busy_to), .preempt(preempt_to));

    bus_arbiter_rr #(.NUM_MASTERS(2), .MAX_HOLD(4), .RR_MODE(1)) u_n2 (
        .clk(clk), .rst(rst), .req_(req_n2), .grnt_(grnt_n2),
        .owner(owner_n2), .busy(busy_n2), .preempt(preempt_n2));

    bus_arbiter_rr #(.NUM_MASTERS(16), .MAX_HOLD(4), .RR_MODE(1)) u_n16 (
        .clk(clk), .rst(rst), .req_(req_n16), .grnt_(grnt_n16),
        .owner(owner_n16), .busy(busy_n16), .preempt(preempt_n16));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic release_all;
        req_rr  = '1;
        req_fp  = '1;
        req_to  = '1;
        req_n2  = '1;
        req_n16 = '1;
    endtask

    task automatic test_reset;
        rst     = 1'b0;
        req_rr  = '0;
        req_fp  = '0;
        req_to  = '0;
        req_n2  = '0;
        req_n16 = '0;
        repeat (2) tick();
        checks++;
        if ({grnt_rr, owner_rr, busy_rr, preempt_rr} !== {4'b1111, 2'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_rr got %b want %b", {grnt_rr, owner_rr, busy_rr, preempt_rr}, {4'b1111, 2'd0, 1'b0, 1'b0});
        end
        checks++;
        if ({grnt_n16, owner_n16, busy_n16, preempt_n16} !== {16'hFFFF, 4'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_n16 got %h/%0d/%b/%b want ffff/0/0/0", grnt_n16, owner_n16, busy_n16, preempt_n16);
        end
        rst = 1'b1;
        #2;
        checks++;
        if ({grnt_rr, busy_rr} !== {4'b1111, 1'b0}) begin
            errors++;
            $display("FAIL reset_release_before_edge got %b want %b", {grnt_rr, busy_rr}, {4'b1111, 1'b0});
        end
        tick();
        checks++;
        if ({grnt_rr, owner_rr, busy_rr, preempt_rr} !== {4'b1101, 2'd1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL first_grant_rr got %b want %b", {grnt_rr, owner_rr, busy_rr, preempt_rr}, {4'b1101, 2'd1, 1'b1, 1'b0});
        end
        checks++;
        if ({grnt_fp, owner_fp, busy_fp} !== {4'b1110, 2'd0, 1'b1}) begin
            errors++;
            $display("FAIL first_grant_fp got %b want %b", {grnt_fp, owner_fp, busy_fp}, {4'b1110, 2'd0, 1'b1});
        end
        release_all();
        repeat (2) tick();
        checks++;
        if ({grnt_rr, owner_rr, busy_rr} !== {4'b1111, 2'd1, 1'b0}) begin
            errors++;
            $display("FAIL idle_after_release got %b want %b", {grnt_rr, owner_rr, busy_rr}, {4'b1111, 2'd1, 1'b0});
        end
    endtask

    task automatic test_single;
        req_rr = 4'b1101;
        tick();
        checks++;
        if ({grnt_rr, owner_rr, busy_rr} !== {4'b1101, 2'd1, 1'b1}) begin
            errors++;
            $display("FAIL single_grant got %b want %b", {grnt_rr, owner_rr, busy_rr}, {4'b1101, 2'd1, 1'b1});
        end
        req_rr = 4'b1111;
        tick();
        checks++;
        if ({grnt_rr, busy_rr} !== {4'b1111, 1'b0}) begin
            errors++;
            $display("FAIL single_release got %b want %b", {grnt_rr, busy_rr}, {4'b1111, 1'b0});
        end
    endtask

    task automatic test_rr_rotation;
        logic [3:0] exp_g;
        int         nxt;
        req_rr = 4'b1110;
        tick();
        checks++;
        if ({grnt_rr, owner_rr} !== {4'b1110, 2'd0}) begin
            errors++;
            $display("FAIL rr_start got %b want %b", {grnt_rr, owner_rr}, {4'b1110, 2'd0});
        end
        for (int i = 0; i < 4; i++) begin
            req_rr = 4'b0000;
            tick();
            exp_g = ~(4'b0001 << i);
            checks++;
            if (grnt_rr !== exp_g) begin
                errors++;
                $display("FAIL rr_hold_%0d got %b want %b", i, grnt_rr, exp_g);
            end
            req_rr = 4'b0001 << i;
            tick();
            nxt   = (i + 1) % 4;
            exp_g = ~(4'b0001 << nxt);
            checks++;
            if ({grnt_rr, owner_rr, busy_rr} !== {exp_g, 2'(nxt), 1'b1}) begin
                errors++;
                $display("FAIL rr_rotate_%0d got %b want %b", i, {grnt_rr, owner_rr, busy_rr}, {exp_g, 2'(nxt), 1'b1});
            end
        end
        req_rr = 4'b1111;
        tick();
    endtask

    task automatic test_fixed_priority;
        req_fp = 4'b0111;
        tick();
        checks++;
        if ({grnt_fp, owner_fp} !== {4'b0111, 2'd3}) begin
            errors++;
            $display("FAIL fp_m3_grant got %b want %b", {grnt_fp, owner_fp}, {4'b0111, 2'd3});
        end
        req_fp = 4'b0010;
        tick();
        checks++;
        if (grnt_fp !== 4'b0111) begin
            errors++;
            $display("FAIL fp_m3_hold got %b want %b", grnt_fp, 4'b0111);
        end
        req_fp = 4'b1010;
        tick();
        checks++;
        if ({grnt_fp, owner_fp, busy_fp} !== {4'b1110, 2'd0, 1'b1}) begin
            errors++;
            $display("FAIL fp_pick_m0 got %b want %b", {grnt_fp, owner_fp, busy_fp}, {4'b1110, 2'd0, 1'b1});
        end
        req_fp = 4'b1111;
        tick();
    endtask

    task automatic test_timeout;
        req_to = 4'b1110;
        tick();
        checks++;
        if ({grnt_to, owner_to, preempt_to} !== {4'b1110, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL to_grant_m0 got %b want %b", {grnt_to, owner_to, preempt_to}, {4'b1110, 2'd0, 1'b0});
        end
        req_to = 4'b1010;
        for (int c = 1; c <= 3; c++) begin
            tick();
            checks++;
            if ({grnt_to, preempt_to} !== {4'b1110, 1'b0}) begin
                errors++;
                $display("FAIL to_hold_%0d got %b want %b", c, {grnt_to, preempt_to}, {4'b1110, 1'b0});
            end
        end
        tick();
        checks++;
        if ({grnt_to, owner_to, preempt_to} !== {4'b1011, 2'd2, 1'b1}) begin
            errors++;
            $display("FAIL to_preempt got %b want %b", {grnt_to, owner_to, preempt_to}, {4'b1011, 2'd2, 1'b1});
        end
        tick();
        checks++;
        if ({grnt_to, preempt_to} !== {4'b1011, 1'b0}) begin
            errors++;
            $display("FAIL to_preempt_pulse got %b want %b", {grnt_to, preempt_to}, {4'b1011, 1'b0});
        end
        req_to = 4'b1111;
        tick();
        req_to = 4'b1110;
        tick();
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++;
            if ({grnt_to, owner_to, preempt_to} !== {4'b1110, 2'd0, 1'b0}) begin
                errors++;
                $display("FAIL to_saturate_%0d got %b want %b", c, {grnt_to, owner_to, preempt_to}, {4'b1110, 2'd0, 1'b0});
            end
        end
        req_to = 4'b1100;
        tick();
        checks++;
        if ({grnt_to, owner_to, preempt_to} !== {4'b1101, 2'd1, 1'b1}) begin
            errors++;
            $display("FAIL to_saturated_preempt got %b want %b", {grnt_to, owner_to, preempt_to}, {4'b1101, 2'd1, 1'b1});
        end
        req_to = 4'b1111;
        tick();
        checks++;
        if ({grnt_to, busy_to, preempt_to} !== {4'b1111, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL to_idle got %b want %b", {grnt_to, busy_to, preempt_to}, {4'b1111, 1'b0, 1'b0});
        end
    endtask

    task automatic test_async_reset;
        req_rr = 4'b1110;
        tick();
        checks++;
        if ({grnt_rr, owner_rr} !== {4'b1110, 2'd0}) begin
            errors++;
            $display("FAIL ar_grant got %b want %b", {grnt_rr, owner_rr}, {4'b1110, 2'd0});
        end
        #1 rst = 1'b0;
        #1;
        checks++;
        if ({grnt_rr, owner_rr, busy_rr, preempt_rr} !== {4'b1111, 2'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL ar_drop got %b want %b", {grnt_rr, owner_rr, busy_rr, preempt_rr}, {4'b1111, 2'd0, 1'b0, 1'b0});
        end
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if ({grnt_rr, owner_rr, busy_rr} !== {4'b1110, 2'd0, 1'b1}) begin
            errors++;
            $display("FAIL ar_restart got %b want %b", {grnt_rr, owner_rr, busy_rr}, {4'b1110, 2'd0, 1'b1});
        end
        req_rr = 4'b1111;
        tick();
    endtask

    task automatic test_param_sweep;
        int w2[2];
        int w16[16];
        int max2;
        int max16;
        foreach (w2[i]) w2[i] = 0;
        foreach (w16[i]) w16[i] = 0;
        req_n2  = '1;
        req_n16 = '1;
        tick();
        for (int c = 0; c < 400; c++) begin
            // Requests low with probability 7/8 to keep masters waiting.
            req_n2  = 2'($urandom & $urandom & $urandom);
            req_n16 = 16'($urandom & $urandom & $urandom);
            tick();
            checks++;
            if ($countones(~grnt_n2) > 1 || busy_n2 !== ~&grnt_n2 || (~grnt_n2 & req_n2) != 2'b00 ||
                (busy_n2 && grnt_n2[owner_n2] !== 1'b0)) begin
                errors++;
                $display("FAIL n2_grant_legal cyc %0d got grnt %b owner %0d busy %b req %b want one-hot-low to requester",
                         c, grnt_n2, owner_n2, busy_n2, req_n2);
            end
            checks++;
            if ($countones(~grnt_n16) > 1 || busy_n16 !== ~&grnt_n16 || (~grnt_n16 & req_n16) != 16'h0000 ||
                (busy_n16 && grnt_n16[owner_n16] !== 1'b0)) begin
                errors++;
                $display("FAIL n16_grant_legal cyc %0d got grnt %h owner %0d busy %b req %h want one-hot-low to requester",
                         c, grnt_n16, owner_n16, busy_n16, req_n16);
            end
            max2  = 0;
            max16 = 0;
            for (int i = 0; i < 2; i++) begin
                if (!grnt_n2[i] || req_n2[i]) w2[i] = 0;
                else w2[i]++;
                if (w2[i] > max2) max2 = w2[i];
            end
            for (int i = 0; i < 16; i++) begin
                if (!grnt_n16[i] || req_n16[i]) w16[i] = 0;
                else w16[i]++;
                if (w16[i] > max16) max16 = w16[i];
            end
            checks++;
            if (max2 > 4) begin
                errors++;
                $display("FAIL n2_starvation cyc %0d got wait %0d want <= 4", c, max2);
            end
            checks++;
            if (max16 > 60) begin
                errors++;
                $display("FAIL n16_starvation cyc %0d got wait %0d want <= 60", c, max16);
            end
        end
        req_n2  = '1;
        req_n16 = '1;
        tick();
    endtask

    initial begin
        release_all();
        test_reset();
        test_single();
        test_rr_rotation();
        test_fixed_priority();
        test_timeout();
        test_async_reset();
        test_param_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
